// File: rtl/row_alloc_if.sv
// Row-remap update bus between the allocation controller and its environment.
//   wt_valid / wt_ready / wt_zero_mask : weight-row descriptor stream into the controller
//   match_success / match_failed / all_faulty_matched : one-cycle update pulses
//   faulty_addr / current_row_addr     : addresses qualifying the update pulse
//   allocation_failed                  : mapping_table feedback, the cycle after a pulse
// The slave modport is the controller; the master modport is the producer/consumer side.
interface row_alloc_if #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
  logic                     wt_valid;
  logic                     wt_ready;
  logic [SYSTOLIC_SIZE-1:0] wt_zero_mask;
  logic                     match_success;
  logic                     match_failed;
  logic                     all_faulty_matched;
  logic [ADDR_WIDTH-1:0]    faulty_addr;
  logic [ADDR_WIDTH-1:0]    current_row_addr;
  logic                     allocation_failed;

  modport master (
    output wt_valid, wt_zero_mask, allocation_failed,
    input  wt_ready, match_success, match_failed, all_faulty_matched,
           faulty_addr, current_row_addr
  );

  modport slave (
    input  wt_valid, wt_zero_mask, allocation_failed,
    output wt_ready, match_success, match_failed, all_faulty_matched,
           faulty_addr, current_row_addr
  );
endinterface

// File: rtl/row_allocation_controller.sv
// Row allocation controller for the mapping table.
// Streams SYSTOLIC_SIZE logical weight rows; for each row it looks for a still-unmatched
// faulty physical row whose faulty columns all carry zero weights in that row, and emits
// exactly one update pulse (match_success / match_failed / all_faulty_matched).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fault_wr_en/addr/data    fault table row write (accepted only when idle or done)
//   faulty_rows_mask         bit i set when physical row i has any faulty PE
//   start                    begins an allocation pass from IDLE or DONE
//   bus (row_alloc_if.slave) descriptor stream, update pulses, allocation feedback
//   busy, done, fail_flag    pass status; fail_flag is sticky for the pass
module row_allocation_controller #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fault_wr_en,
  input  logic [ADDR_WIDTH-1:0]    fault_wr_addr,
  input  logic [SYSTOLIC_SIZE-1:0] fault_wr_data,
  output logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask,
  input  logic                     start,
  row_alloc_if.slave               bus,
  output logic                     busy,
  output logic                     done,
  output logic                     fail_flag
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ROW = 3'd1,
    ISSUE    = 3'd2,
    CHECK    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                   state;
  logic [SYSTOLIC_SIZE-1:0] fault_table [SYSTOLIC_SIZE];
  logic [SYSTOLIC_SIZE-1:0] matched;
  logic [ADDR_WIDTH-1:0]    row_cnt;

  logic                     cand_found;
  logic [ADDR_WIDTH-1:0]    cand_idx;
  logic                     any_unmatched;

  always_comb begin
    faulty_rows_mask = '0;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      faulty_rows_mask[i] = |fault_table[i];
    end
  end

  // Candidate search runs against the descriptor being accepted, so the pulse can be
  // registered at the accept edge and appear during ISSUE. The table cannot change while
  // busy and matched only changes at the end of ISSUE, so this sees the same state that
  // ISSUE would. Descending scan leaves the lowest-index candidate in cand_idx.
  always_comb begin
    cand_found    = 1'b0;
    cand_idx      = '0;
    any_unmatched = 1'b0;
    for (int f = SYSTOLIC_SIZE - 1; f >= 0; f--) begin
      if (faulty_rows_mask[f] && !matched[f]) begin
        any_unmatched = 1'b1;
        if ((fault_table[f] & ~bus.wt_zero_mask) == '0) begin
          cand_found = 1'b1;
          cand_idx   = ADDR_WIDTH'(f);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      row_cnt                <= '0;
      matched                <= '0;
      fail_flag              <= 1'b0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      bus.wt_ready           <= 1'b0;
      bus.match_success      <= 1'b0;
      bus.match_failed       <= 1'b0;
      bus.all_faulty_matched <= 1'b0;
      bus.faulty_addr        <= '0;
      bus.current_row_addr   <= '0;
      for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
        fault_table[i] <= '0;
      end
    end else begin
      // Pulses and faulty_addr live for a single cycle unless re-armed below.
      bus.match_success      <= 1'b0;
      bus.match_failed       <= 1'b0;
      bus.all_faulty_matched <= 1'b0;
      bus.faulty_addr        <= '0;

      if (fault_wr_en && (state == IDLE || state == DONE)) begin
        fault_table[fault_wr_addr] <= fault_wr_data;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= WAIT_ROW;
            matched      <= '0;
            row_cnt      <= '0;
            fail_flag    <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
            bus.wt_ready <= 1'b1;
          end
        end

        // Accept edge (T): latch row index and arm exactly one update pulse for T+1.
        WAIT_ROW: begin
          if (bus.wt_valid && bus.wt_ready) begin
            state                <= ISSUE;
            bus.wt_ready         <= 1'b0;
            bus.current_row_addr <= row_cnt;
            if (cand_found) begin
              bus.match_success <= 1'b1;
              bus.faulty_addr   <= cand_idx;
            end else if (any_unmatched) begin
              bus.match_failed <= 1'b1;
            end else begin
              bus.all_faulty_matched <= 1'b1;
            end
          end
        end

        // Issue cycle (T+1): pulse visible; a successful match retires that faulty row.
        ISSUE: begin
          state <= CHECK;
          if (bus.match_success) begin
            matched[bus.faulty_addr] <= 1'b1;
          end
        end

        // Check cycle (T+2): mapping_table feedback, advance to the next row.
        CHECK: begin
          if (bus.allocation_failed) begin
            fail_flag <= 1'b1;
          end
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == LAST_ROW) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state        <= WAIT_ROW;
            bus.wt_ready <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          done         <= 1'b0;
          bus.wt_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_allocation_controller.sv
module tb_row_allocation_controller;

  localparam int S  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fault_wr_en = 1'b0;
  logic [AW-1:0] fault_wr_addr = '0;
  logic [S-1:0]  fault_wr_data = '0;
  logic [S-1:0]  faulty_rows_mask;
  logic          start = 1'b0;
  logic          busy, done, fail_flag;

  row_alloc_if #(.SYSTOLIC_SIZE(S), .ADDR_WIDTH(AW)) bus ();

  row_allocation_controller #(.SYSTOLIC_SIZE(S), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .fault_wr_en      (fault_wr_en),
    .fault_wr_addr    (fault_wr_addr),
    .fault_wr_data    (fault_wr_data),
    .faulty_rows_mask (faulty_rows_mask),
    .start            (start),
    .bus              (bus),
    .busy             (busy),
    .done             (done),
    .fail_flag        (fail_flag)
  );

  always #5 clk = ~clk;

  // pulses = {match_success, match_failed, all_faulty_matched}
  typedef struct {
    logic [S-1:0]  zmask;
    logic          afail;
    logic [2:0]    pulses;
    logic [AW-1:0] faddr;
    logic          exp_fail;
  } row_vec_t;

  localparam logic [2:0] P_SUC = 3'b100;
  localparam logic [2:0] P_FLD = 3'b010;
  localparam logic [2:0] P_ALL = 3'b001;

  row_vec_t vecs [44];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [S-1:0] zm, input logic af,
                      input logic [2:0] p, input logic [AW-1:0] fa, input logic ef);
    vecs[i].zmask    = zm;
    vecs[i].afail    = af;
    vecs[i].pulses   = p;
    vecs[i].faddr    = fa;
    vecs[i].exp_fail = ef;
  endtask

  task automatic wr_fault(input logic [AW-1:0] a, input logic [S-1:0] d);
    @(negedge clk);
    fault_wr_en = 1'b1; fault_wr_addr = a; fault_wr_data = d;
    @(negedge clk);
    fault_wr_en = 1'b0;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < S; i++) wr_fault(AW'(i), '0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_row(input row_vec_t v, input int r, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.wt_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_r%0d_ready_wait", tag, r), 32'(n < 20), 32'd1);
    bus.wt_valid = 1'b1;
    bus.wt_zero_mask = v.zmask;
    @(negedge clk);
    bus.wt_valid = 1'b0;
    chk($sformatf("%s_r%0d_pulses", tag, r),
        {29'd0, bus.match_success, bus.match_failed, bus.all_faulty_matched}, {29'd0, v.pulses});
    chk($sformatf("%s_r%0d_faddr", tag, r), 32'(bus.faulty_addr), 32'(v.faddr));
    chk($sformatf("%s_r%0d_row", tag, r), 32'(bus.current_row_addr), r);
    chk($sformatf("%s_r%0d_ready_issue", tag, r), 32'(bus.wt_ready), 32'd0);
    @(negedge clk);
    chk($sformatf("%s_r%0d_pulses_check", tag, r),
        {29'd0, bus.match_success, bus.match_failed, bus.all_faulty_matched}, 32'd0);
    chk($sformatf("%s_r%0d_ready_check", tag, r), 32'(bus.wt_ready), 32'd0);
    bus.allocation_failed = v.afail;
    @(negedge clk);
    bus.allocation_failed = 1'b0;
    chk($sformatf("%s_r%0d_fail_flag", tag, r), 32'(fail_flag), 32'(v.exp_fail));
  endtask

  task automatic run_rows(input int base, input int n, input string tag);
    for (int r = 0; r < n; r++) do_row(vecs[base + r], r, tag);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pulses"}, {29'd0, bus.match_success, bus.match_failed, bus.all_faulty_matched}, 32'd0);
    chk({tag, "_faddr"}, 32'(bus.faulty_addr), 32'd0);
    chk({tag, "_row"}, 32'(bus.current_row_addr), 32'd0);
    chk({tag, "_ready"}, 32'(bus.wt_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_fail_flag"}, 32'(fail_flag), 32'd0);
    chk({tag, "_mask"}, 32'(faulty_rows_mask), 32'd0);
  endtask

  task automatic chk_done(input string tag, input logic ef);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready_done"}, 32'(bus.wt_ready), 32'd0);
    chk({tag, "_fail_done"}, 32'(fail_flag), 32'(ef));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wt_valid = 1'b0;
    bus.wt_zero_mask = '0;
    bus.allocation_failed = 1'b0;

    // Pass A: no faults, arbitrary masks
    for (int r = 0; r < 8; r++) setv(r, 8'(r * 37), 1'b0, P_ALL, 3'd0, 1'b0);
    // Pass B: fault_table[3]=04
    setv(8, 8'h00, 1'b0, P_FLD, 3'd0, 1'b0);
    setv(9, 8'h04, 1'b0, P_SUC, 3'd3, 1'b0);
    for (int r = 2; r < 8; r++) setv(8 + r, 8'h00, 1'b0, P_ALL, 3'd0, 1'b0);
    // Pass C: fault_table[2]=fault_table[5]=01
    setv(16, 8'hFF, 1'b0, P_SUC, 3'd2, 1'b0);
    setv(17, 8'hFF, 1'b0, P_SUC, 3'd5, 1'b0);
    for (int r = 2; r < 8; r++) setv(16 + r, 8'hFF, 1'b0, P_ALL, 3'd0, 1'b0);
    // Pass D: fault_table[1]=80, [6]=81, allocation_failed on row 4
    setv(24, 8'h00, 1'b0, P_FLD, 3'd0, 1'b0);
    setv(25, 8'h80, 1'b0, P_SUC, 3'd1, 1'b0);
    setv(26, 8'h80, 1'b0, P_FLD, 3'd0, 1'b0);
    setv(27, 8'h81, 1'b0, P_SUC, 3'd6, 1'b0);
    setv(28, 8'hFF, 1'b1, P_ALL, 3'd0, 1'b1);
    for (int r = 5; r < 8; r++) setv(24 + r, 8'hFF, 1'b0, P_ALL, 3'd0, 1'b1);
    // Pass E: fault_table[4]=10, rows 0..3 then reset
    for (int r = 0; r < 4; r++) setv(32 + r, 8'h00, 1'b0, P_FLD, 3'd0, 1'b0);
    // Pass F: after reset, no faults
    for (int r = 0; r < 8; r++) setv(36 + r, 8'h10, 1'b0, P_ALL, 3'd0, 1'b0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");

    // Pass A, with a fault write attempted while busy
    do_start();
    chk("A_busy", 32'(busy), 32'd1);
    chk("A_done_low", 32'(done), 32'd0);
    wr_fault(3'd0, 8'hFF);
    chk("A_busy_write_ignored", 32'(faulty_rows_mask), 32'd0);
    run_rows(0, 8, "A");
    chk_done("A", 1'b0);

    // Pass B
    wr_fault(3'd3, 8'h04);
    chk("B_mask", 32'(faulty_rows_mask), 32'h08);
    do_start();
    run_rows(8, 8, "B");
    chk_done("B", 1'b0);

    // Pass C
    clear_faults();
    wr_fault(3'd2, 8'h01);
    wr_fault(3'd5, 8'h01);
    chk("C_mask", 32'(faulty_rows_mask), 32'h24);
    do_start();
    run_rows(16, 8, "C");
    chk_done("C", 1'b0);

    // Pass D
    clear_faults();
    wr_fault(3'd1, 8'h80);
    wr_fault(3'd6, 8'h81);
    chk("D_mask", 32'(faulty_rows_mask), 32'h42);
    do_start();
    run_rows(24, 8, "D");
    chk_done("D", 1'b1);

    // Pass E: new start clears fail_flag; reset mid-pass
    clear_faults();
    wr_fault(3'd4, 8'h10);
    do_start();
    chk("E_fail_cleared", 32'(fail_flag), 32'd0);
    run_rows(32, 4, "E");
    chk("E_mask_before_rst", 32'(faulty_rows_mask), 32'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("midrst");
    @(negedge clk);
    chk("midrst_no_pulse", {29'd0, bus.match_success, bus.match_failed, bus.all_faulty_matched}, 32'd0);

    // Pass F: table cleared by reset
    do_start();
    run_rows(36, 8, "F");
    chk_done("F", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
